gbe_tx_sequencer: RTL
=====================

# gbe_tx_sequencer

Frame sequencer for the ten-GbE transmit path in the user clock domain. It generates counter-pattern frames of programmable length at a programmable start-to-start period and drives the core's tx handshake, holding back frame starts while the core signals almost-full. Its `tx_count` output feeds the software-readable tx counter register, and `ovf_count` feeds an overflow register; both cross to the bus domain through that register block.

## Interface

Parameters:
- `LEN_WIDTH`, 16, width of the frame-length input, in 64-bit words.
- `PERIOD_WIDTH`, 32, width of the start-to-start period input, in cycles.

Ports:
- `user_clk`  in  1  sole clock.
- `user_rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; frames are generated while high.
- `pkt_len`  in  LEN_WIDTH  frame length in words; 0 is treated as 1.
- `period`  in  PERIOD_WIDTH  cycles from one frame's first word to the next frame's first word.
- `dest_ip`  in  32  destination IP, latched per frame.
- `dest_port`  in  16  destination UDP port, latched per frame.
- `tx_afull`  in  1  core almost-full flag.
- `tx_overflow`  in  1  core overflow pulse.
- `tx_data`  out  64  payload word.
- `tx_valid`  out  1  word strobe.
- `tx_end_of_frame`  out  1  last word of the frame; asserted together with `tx_valid`.
- `tx_dest_ip`  out  32  latched destination IP.
- `tx_dest_port`  out  16  latched destination port.
- `tx_count`  out  32  frames completed.
- `ovf_count`  out  32  overflow events.
- `busy`  out  1  high while in SEND.

## Operation

The sequencer has three states: IDLE, SEND and GAP.

- **IDLE**
  - If `enable`=1 and `tx_afull`=0, latch `len_q`=max(`pkt_len`,1), `dest_ip` and `dest_port`.
  - Load the period timer with max(`period`,`len_q`)−1, clear `word_idx`, and go to SEND.
  - Otherwise stay in IDLE.
- **SEND**
  - Assert `tx_valid` each cycle.
  - `tx_data` = {`pkt_num`[31:0], `word_idx`[31:0]}; `word_idx` increments each cycle.
  - On `word_idx` = `len_q`−1, assert `tx_end_of_frame`, increment `pkt_num` and `tx_count`, and go to GAP.
  - `tx_afull` is ignored mid-frame; the core's almost-full headroom covers one frame.
  - `enable` falling mid-frame does not truncate the frame.
- **GAP**
  - The timer decrements every cycle, including cycles spent in SEND.
  - When the timer is 0:
    - `enable`=0 → go to IDLE.
    - `enable`=1 and `tx_afull`=0 → start the next frame exactly as in IDLE.
    - `enable`=1 and `tx_afull`=1 → hold in GAP with the timer at 0 until `tx_afull` falls.
  - The deferred start is not made up later; the period is re-measured from the actual start.
- **Counters**
  - `tx_count` wraps modulo 2^32.
  - `ovf_count` increments on each cycle `tx_overflow`=1 and saturates at 0xFFFFFFFF.
  - Both counters update independently of state and are cleared only by reset.
  - `pkt_num` restarts at 0 only on reset; a disable/enable cycle does not clear it.
- **Width rules**
  - `len_q` is zero-extended to PERIOD_WIDTH before the max() with `period`.
  - `period`=0 or `period` < `len_q` gives back-to-back frames.
  - `pkt_len` and `period` changes take effect only at the next frame start.

## Timing

- **Reset values:** all outputs 0 (`tx_data`, `tx_valid`, `tx_end_of_frame`, `tx_dest_ip`, `tx_dest_port`, `tx_count`, `ovf_count`, `busy`); state IDLE; `pkt_num`=0; timer=0.
- **Start latency:** all outputs are registered. `enable` and `tx_afull` sampled high/low at edge N give the first `tx_valid` in the cycle after edge N (visible from N+1).
- **Frame cadence:** first words are exactly max(`period`,`len_q`) cycles apart while unblocked.
- **Back-to-back frames:** no idle cycle between an EOF word and the next first word when `period` ≤ `len_q`.
- **`tx_count` update:** `tx_count` shows the new value in the cycle after the EOF word.
- **`ovf_count` update:** `ovf_count` updates one cycle after the `tx_overflow` sample.
- **Simultaneous events:** the EOF increment and an overflow increment in the same cycle are both applied.
- **Reset mid-frame:** the next cycle has `tx_valid`=0 and no EOF is emitted. The partial frame is not counted, and the core discards it.
- **Single-word frames:** `len_q`=1 asserts `tx_valid` and `tx_end_of_frame` in the same cycle.

## Test plan

- **Basic cadence:** reset, `pkt_len`=4, `period`=10, `enable`=1 for 40 cycles → 4 frames of 4 words with first words 10 cycles apart; `tx_data` of frame 2, word 3 = 0x00000002_00000003; `tx_count`=4.
- **Back-to-back:** `pkt_len`=8, `period`=3 → continuous `tx_valid`, EOF every 8th word, no gap cycles.
- **Backpressure:** hold `tx_afull`=1 from mid-frame 1 for 20 cycles with `period`=10 → frame 1 completes intact; the next start occurs 1 cycle after `tx_afull` falls; later starts are measured from that start.
- **Zero length and wrap:** `pkt_len`=0 → single-word frames with `tx_valid` and EOF together. Force `tx_count` to 0xFFFFFFFF, then one frame → `tx_count`=0.
- **Overflow saturation:** 3 `tx_overflow` pulses → `ovf_count`=3. Force `ovf_count` to 0xFFFFFFFE, then 2 pulses → 0xFFFFFFFF.
- **Reset and disable mid-frame:** assert `user_rst` at word 2 of a 6-word frame → all outputs 0 next cycle, `tx_count` unchanged at 0. Separately, drop `enable` at word 2 → the frame finishes all 6 words, then the sequencer returns to IDLE.

Source files
------------

// File: rtl/gbe_tx_sequencer.sv
// Counter-pattern frame generator for the 10GbE transmit path (user clock domain).
// Emits frames of pkt_len words at a fixed start-to-start period, deferring starts on almost-full.
module gbe_tx_sequencer #(
    parameter int unsigned LEN_WIDTH    = 16,
    parameter int unsigned PERIOD_WIDTH = 32
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    input  logic                    enable,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [31:0]             dest_ip,
    input  logic [15:0]             dest_port,
    input  logic                    tx_afull,
    input  logic                    tx_overflow,
    output logic [63:0]             tx_data,
    output logic                    tx_valid,
    output logic                    tx_end_of_frame,
    output logic [31:0]             tx_dest_ip,
    output logic [15:0]             tx_dest_port,
    output logic [31:0]             tx_count,
    output logic [31:0]             ovf_count,
    output logic                    busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]              r_state;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [PERIOD_WIDTH-1:0] r_timer;
    logic [31:0]             r_word_idx;
    logic [31:0]             r_pkt_num;
    logic [31:0]             r_tx_count;
    logic [31:0]             r_ovf_count;
    logic [63:0]             r_tx_data;
    logic                    r_tx_valid;
    logic                    r_tx_eof;
    logic [31:0]             r_dest_ip;
    logic [15:0]             r_dest_port;
    logic                    r_busy;

    logic [LEN_WIDTH-1:0]    w_len_new;
    logic [PERIOD_WIDTH-1:0] w_len_ext;
    logic [PERIOD_WIDTH-1:0] w_timer_load;
    logic [31:0]             w_last_idx;
    logic [31:0]             w_next_idx;
    logic [31:0]             w_pkt_next;
    logic [31:0]             w_start_pkt;
    logic                    w_last;
    logic                    w_start;
    logic                    w_finish;
    logic [1:0]              w_state_d;

    assign w_len_new    = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
    assign w_len_ext    = PERIOD_WIDTH'(w_len_new);
    assign w_timer_load = ((period > w_len_ext) ? period : w_len_ext) - PERIOD_WIDTH'(1);
    assign w_last_idx   = 32'(r_len) - 32'd1;
    assign w_next_idx   = r_word_idx + 32'd1;
    assign w_last       = (r_word_idx == w_last_idx);
    assign w_pkt_next   = r_pkt_num + 32'd1;
    // A frame starting on the same edge its predecessor ends carries the bumped packet number.
    assign w_start_pkt  = w_finish ? w_pkt_next : r_pkt_num;

    // The EOF edge evaluates the gap decision directly so period <= len yields no idle cycle.
    always_comb begin
        w_start   = 1'b0;
        w_finish  = 1'b0;
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable && !tx_afull) begin
                    w_start = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_last) begin
                    w_finish  = 1'b1;
                    w_state_d = ST_GAP;
                    if (r_timer == '0) begin
                        if (!enable) begin
                            w_state_d = ST_IDLE;
                        end else if (!tx_afull) begin
                            w_start = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (r_timer == '0) begin
                    if (!enable) begin
                        w_state_d = ST_IDLE;
                    end else if (!tx_afull) begin
                        w_start = 1'b1;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        if (w_start) begin
            w_state_d = ST_SEND;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_timer     <= '0;
            r_word_idx  <= '0;
            r_pkt_num   <= '0;
            r_tx_count  <= '0;
            r_ovf_count <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_eof    <= 1'b0;
            r_dest_ip   <= '0;
            r_dest_port <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_finish) begin
                r_pkt_num  <= w_pkt_next;
                r_tx_count <= r_tx_count + 32'd1;
            end
            if (tx_overflow && (r_ovf_count != 32'hFFFF_FFFF)) begin
                r_ovf_count <= r_ovf_count + 32'd1;
            end
            if (w_start) begin
                r_len       <= w_len_new;
                r_dest_ip   <= dest_ip;
                r_dest_port <= dest_port;
                r_timer     <= w_timer_load;
                r_word_idx  <= '0;
                r_tx_valid  <= 1'b1;
                r_tx_data   <= {w_start_pkt, 32'd0};
                r_tx_eof    <= (w_len_new == LEN_WIDTH'(1));
                r_busy      <= 1'b1;
            end else begin
                if (r_timer != '0) begin
                    r_timer <= r_timer - PERIOD_WIDTH'(1);
                end
                if ((r_state == ST_SEND) && !w_last) begin
                    r_word_idx <= w_next_idx;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= {r_pkt_num, w_next_idx};
                    r_tx_eof   <= (w_next_idx == w_last_idx);
                    r_busy     <= 1'b1;
                end else begin
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= '0;
                    r_tx_eof   <= 1'b0;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign tx_data         = r_tx_data;
    assign tx_valid        = r_tx_valid;
    assign tx_end_of_frame = r_tx_eof;
    assign tx_dest_ip      = r_dest_ip;
    assign tx_dest_port    = r_dest_port;
    assign tx_count        = r_tx_count;
    assign ovf_count       = r_ovf_count;
    assign busy            = r_busy;

endmodule
